// File: rtl/alu_pkg.sv
// Shared definitions for the ripple-ALU issue controller.
// Holds the opcode encoding, the slice function-select codes and the
// sequencing state encoding used by alu_issue_ctrl and alu_op_decode.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_NOR  = 4'd0,
      OP_NAND = 4'd1,
      OP_OR   = 4'd2,
      OP_AND  = 4'd3,
      OP_XOR  = 4'd4,
      OP_XNOR = 4'd5,
      OP_ADD  = 4'd6,
      OP_SUB  = 4'd7,
      OP_SLT  = 4'd8
   } op_e;

   // {C1,C2,C3} function-select codes understood by every slice
   localparam logic [2:0] CTL_NOR   = 3'b000;
   localparam logic [2:0] CTL_NAND  = 3'b001;
   localparam logic [2:0] CTL_OR    = 3'b010;
   localparam logic [2:0] CTL_AND   = 3'b011;
   localparam logic [2:0] CTL_XOR   = 3'b100;
   localparam logic [2:0] CTL_XNOR  = 3'b101;
   localparam logic [2:0] CTL_ARITH = 3'b110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder for the slice array.
// Ports:
//   op        in  4  opcode
//   c1,c2,c3  out 1  slice function select
//   sub       out 1  invert B inside the slices
//   cin       out 1  carry into slice 0
//   is_arith  out 1  ADD/SUB/SLT (carry and overflow are meaningful)
//   is_slt    out 1  set-less-than result shaping
//   illegal   out 1  opcode outside the defined map
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0] op,
   output logic       c1,
   output logic       c2,
   output logic       c3,
   output logic       sub,
   output logic       cin,
   output logic       is_arith,
   output logic       is_slt,
   output logic       illegal
);

   logic [2:0] ctl_s;

   // opcode to slice control lines
   always_comb begin
      ctl_s    = CTL_NOR;
      sub      = 1'b0;
      cin      = 1'b0;
      is_arith = 1'b0;
      is_slt   = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_NOR:  ctl_s = CTL_NOR;
         OP_NAND: ctl_s = CTL_NAND;
         OP_OR:   ctl_s = CTL_OR;
         OP_AND:  ctl_s = CTL_AND;
         OP_XOR:  ctl_s = CTL_XOR;
         OP_XNOR: ctl_s = CTL_XNOR;
         OP_ADD: begin
            ctl_s    = CTL_ARITH;
            is_arith = 1'b1;
         end
         OP_SUB: begin
            ctl_s    = CTL_ARITH;
            sub      = 1'b1;
            cin      = 1'b1;
            is_arith = 1'b1;
         end
         OP_SLT: begin
            ctl_s    = CTL_ARITH;
            sub      = 1'b1;
            cin      = 1'b1;
            is_arith = 1'b1;
            is_slt   = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   assign c1 = ctl_s[2];
   assign c2 = ctl_s[1];
   assign c3 = ctl_s[0];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencing front-end for a W-bit ripple ALU built from 1-bit slices.
// Accepts one operation per request handshake, drives registered operands
// and decoded controls into the slice array, waits SETTLE cycles for the
// carry ripple, then captures the result and flags onto a response port.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          request handshake
//   req_op, req_a, req_b         opcode and operands
//   alu_a, alu_b                 registered operands to the slices
//   alu_c1..c3, alu_sub, alu_cin registered slice controls
//   alu_out, alu_cout            slice array output and top carry
//   rsp_valid/rsp_ready          response handshake
//   rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err  response payload
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int W      = 16,
   parameter int SETTLE = 4
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_c1,
   output logic         alu_c2,
   output logic         alu_c3,
   output logic         alu_sub,
   output logic         alu_cin,
   input  logic [W-1:0] alu_out,
   input  logic         alu_cout,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_carry,
   output logic         rsp_ovf,
   output logic         rsp_err
);

   localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]  CNT_LOAD = CW'(SETTLE - 1);

   state_e         state_r, state_nx;
   logic [CW-1:0]  cnt_r;
   logic           arith_r, slt_r;

   logic dec_c1, dec_c2, dec_c3, dec_sub, dec_cin;
   logic dec_arith, dec_slt, dec_illegal;

   logic           b_msb_s, ovf_s, carry_s;
   logic [W-1:0]   result_s;

   alu_op_decode u_dec (
      .op       (req_op),
      .c1       (dec_c1),
      .c2       (dec_c2),
      .c3       (dec_c3),
      .sub      (dec_sub),
      .cin      (dec_cin),
      .is_arith (dec_arith),
      .is_slt   (dec_slt),
      .illegal  (dec_illegal)
   );

   // next-state selection
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (req_valid) state_nx = dec_illegal ? RESP : DRIVE;
            else           state_nx = IDLE;
         end
         DRIVE: begin
            if (cnt_r == '0) state_nx = RESP;
            else             state_nx = DRIVE;
         end
         RESP: begin
            if (rsp_ready) state_nx = IDLE;
            else           state_nx = RESP;
         end
         default: state_nx = IDLE;
      endcase
   end

   // capture-time result shaping; overflow uses the B actually seen by
   // the slices (inverted for SUB/SLT), SLT reports sign xor overflow
   always_comb begin
      b_msb_s  = alu_b[W-1] ^ alu_sub;
      ovf_s    = arith_r && (alu_a[W-1] == b_msb_s) && (alu_out[W-1] != alu_a[W-1]);
      carry_s  = arith_r ? alu_cout : 1'b0;
      if (slt_r) result_s = {{(W-1){1'b0}}, alu_out[W-1] ^ ovf_s};
      else       result_s = alu_out;
   end

   // state register, operand/control latches and response capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         arith_r    <= 1'b0;
         slt_r      <= 1'b0;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_c1     <= 1'b0;
         alu_c2     <= 1'b0;
         alu_c3     <= 1'b0;
         alu_sub    <= 1'b0;
         alu_cin    <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_carry  <= 1'b0;
         rsp_ovf    <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         state_r   <= state_nx;
         req_ready <= (state_nx == IDLE);
         rsp_valid <= (state_nx == RESP);
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  if (dec_illegal) begin
                     // slices keep their previous drive; only the response changes
                     rsp_result <= '0;
                     rsp_zero   <= 1'b0;
                     rsp_carry  <= 1'b0;
                     rsp_ovf    <= 1'b0;
                     rsp_err    <= 1'b1;
                  end else begin
                     alu_a   <= req_a;
                     alu_b   <= req_b;
                     alu_c1  <= dec_c1;
                     alu_c2  <= dec_c2;
                     alu_c3  <= dec_c3;
                     alu_sub <= dec_sub;
                     alu_cin <= dec_cin;
                     arith_r <= dec_arith;
                     slt_r   <= dec_slt;
                     cnt_r   <= CNT_LOAD;
                  end
               end
            end
            DRIVE: begin
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - 1'b1;
               end else begin
                  rsp_result <= result_s;
                  rsp_zero   <= (result_s == '0);
                  rsp_carry  <= carry_s;
                  rsp_ovf    <= ovf_s;
                  rsp_err    <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed self-checking bench for alu_issue_ctrl with a behavioural
// model of the 16-bit slice array closing the loop.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a, req_b;
   logic [15:0] alu_a, alu_b, alu_out;
   logic        alu_c1, alu_c2, alu_c3, alu_sub, alu_cin, alu_cout;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic        rsp_zero, rsp_carry, rsp_ovf, rsp_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.W(16), .SETTLE(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_c1(alu_c1), .alu_c2(alu_c2), .alu_c3(alu_c3),
      .alu_sub(alu_sub), .alu_cin(alu_cin),
      .alu_out(alu_out), .alu_cout(alu_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
      .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
   );

   // behavioural slice array
   logic [16:0] sum;
   always_comb begin
      sum = {1'b0, alu_a} + {1'b0, alu_b ^ {16{alu_sub}}} + {16'd0, alu_cin};
      alu_cout = 1'b0;
      case ({alu_c1, alu_c2, alu_c3})
         3'b000: alu_out = ~(alu_a | alu_b);
         3'b001: alu_out = ~(alu_a & alu_b);
         3'b010: alu_out = alu_a | alu_b;
         3'b011: alu_out = alu_a & alu_b;
         3'b100: alu_out = alu_a ^ alu_b;
         3'b101: alu_out = ~(alu_a ^ alu_b);
         3'b110: begin
            alu_out  = sum[15:0];
            alu_cout = sum[16];
         end
         default: alu_out = 16'h0000;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // present one request and return #1 after the accept edge
   task automatic accept(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // edges after the accept edge until rsp_valid, bounded
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic finish_rsp();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("req_ready_back", req_ready, 1);
   endtask

   // ctl = {c1,c2,c3,sub,cin}; flags = {zero,carry,ovf,err}
   task automatic run(input string tag, input logic [3:0] op,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ea, input logic [15:0] eb,
                      input logic [4:0] ectl, input int elat,
                      input logic [15:0] eres, input logic [3:0] eflags);
      int lat;
      accept(op, a, b);
      chk({tag, "_alu_a"}, alu_a, ea);
      chk({tag, "_alu_b"}, alu_b, eb);
      chk({tag, "_ctl"}, {alu_c1, alu_c2, alu_c3, alu_sub, alu_cin}, ectl);
      chk({tag, "_ready_busy"}, req_ready, 0);
      wait_rsp(lat);
      chk({tag, "_latency"}, lat, elat);
      chk({tag, "_result"}, rsp_result, eres);
      chk({tag, "_flags"}, {rsp_zero, rsp_carry, rsp_ovf, rsp_err}, eflags);
      finish_rsp();
   endtask

   initial begin
      int lat;
      rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 16'd0; req_b = 16'd0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_ab", {alu_a, alu_b}, 0);
      chk("rst_ctl", {alu_c1, alu_c2, alu_c3, alu_sub, alu_cin}, 0);
      chk("rst_rsp", {rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err}, 0);
      @(negedge clk);
      rst = 1'b0;

      run("add_ovf", 4'd6, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001, 5'b11000, 4, 16'h8000, 4'b0010);
      run("sub_eq",  4'd7, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 5'b11011, 4, 16'h0000, 4'b1100);
      run("slt_neg", 4'd8, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 5'b11011, 4, 16'h0001, 4'b0100);
      run("slt_ovf", 4'd8, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 5'b11011, 4, 16'h0001, 4'b0110);
      run("slt_ge",  4'd8, 16'h0003, 16'h0002, 16'h0003, 16'h0002, 5'b11011, 4, 16'h0000, 4'b1100);
      // illegal opcode: slices keep the previous SLT drive
      run("illegal", 4'hC, 16'h1234, 16'h5678, 16'h0003, 16'h0002, 5'b11011, 0, 16'h0000, 4'b0001);
      run("nor",     4'd0, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b00000, 4, 16'hF000, 4'b0000);
      run("nand",    4'd1, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b00100, 4, 16'hFFF0, 4'b0000);
      run("or",      4'd2, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b01000, 4, 16'h0FFF, 4'b0000);
      run("and",     4'd3, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b01100, 4, 16'h000F, 4'b0000);
      run("xor",     4'd4, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b10000, 4, 16'h0FF0, 4'b0000);
      run("xnor",    4'd5, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h0F0F, 5'b10100, 4, 16'hF00F, 4'b0000);

      // back-pressure: response held for 10 cycles, new request ignored
      accept(4'd6, 16'h0001, 16'h0002);
      wait_rsp(lat);
      chk("bp_latency", lat, 4);
      @(negedge clk);
      req_valid = 1'b1; req_op = 4'd7; req_a = 16'h00AA; req_b = 16'h0055;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_valid", rsp_valid, 1);
         chk("bp_ready", req_ready, 0);
         chk("bp_result", {rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err}, {16'h0003, 4'b0000});
         chk("bp_alu_a", alu_a, 16'h0001);
      end
      req_valid = 1'b0;
      finish_rsp();

      // reset while in DRIVE drops the operation
      accept(4'd6, 16'h0010, 16'h0020);
      @(posedge clk); #1;
      chk("drv_busy", req_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_alu", {alu_a, alu_b, alu_c1, alu_c2, alu_c3, alu_sub, alu_cin}, 0);
      chk("mid_rst_rsp", {rsp_result, rsp_zero, rsp_carry, rsp_ovf, rsp_err}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("no_rsp_after_rst", rsp_valid, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
